// File: rtl/naive_intt_seq.sv
// ============================================================================
// naive_intt_seq: sequential naive inverse NTT over Z_q, one shared mul/mod path
// Optional forward mode: define NTT_FWD_MODE_EN.      Revision: 1.0
// ============================================================================
`default_nettype none

module naive_intt_seq #(
   parameter int N = 8,
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
`ifdef NTT_FWD_MODE_EN
   input  logic           fwd,
`endif
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*W-1:0] data_in,
   input  logic [W-1:0]   omega_inv,
   input  logic [W-1:0]   n_inv,
   input  logic [W-1:0]   mod,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*W-1:0] data_out,
   output logic           err
);

   localparam int LG = $clog2(N);
   localparam logic [LG-1:0] LAST = LG'(N - 1);

   typedef enum logic [2:0] {IDLE, POW, MAC, SCALE, DONE} state_t;

   state_t         state_q, state_d;
   logic [N*W-1:0] x_q, x_d;
   logic [N*W-1:0] res_q, res_d;
   logic [W-1:0]   omega_q, omega_d;
   logic [W-1:0]   ninv_q, ninv_d;
   logic [W-1:0]   mod_q, mod_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [W-1:0]   pow_q [N];
   logic [W-1:0]   pow_d [N];
   logic [LG-1:0]  k_q, k_d, i_q, i_d, j_q, j_d, e_q, e_d;
   logic           err_q, err_d;
   logic           fwd_q, fwd_d;

   logic [W-1:0]   mul_a, mul_b, mul_red, acc_next;
   logic [2*W-1:0] mul_prod;
   logic [W:0]     acc_sum;
   logic [LG-1:0]  k_prev;

   // Single shared multiply/reduce datapath; operands are muxed by state.
   assign mul_prod = mul_a * mul_b;
   assign mul_red  = W'(mul_prod % (2*W)'(mod_q));
   assign acc_sum  = {1'b0, acc_q} + {1'b0, mul_red};
   assign acc_next = W'((acc_sum >= {1'b0, mod_q}) ? acc_sum - {1'b0, mod_q} : acc_sum);
   assign k_prev   = k_q - LG'(1);

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign data_out  = res_q;
   assign err       = err_q;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      res_d   = res_q;
      omega_d = omega_q;
      ninv_d  = ninv_q;
      mod_d   = mod_q;
      acc_d   = acc_q;
      pow_d   = pow_q;
      k_d     = k_q;
      i_d     = i_q;
      j_d     = j_q;
      e_d     = e_q;
      err_d   = err_q;
      fwd_d   = fwd_q;
      mul_a   = '0;
      mul_b   = '0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = data_in;
               omega_d = omega_inv;
               ninv_d  = n_inv;
               mod_d   = mod;
`ifdef NTT_FWD_MODE_EN
               fwd_d   = fwd;
`else
               fwd_d   = 1'b0;
`endif
               acc_d   = '0;
               k_d     = '0;
               i_d     = '0;
               j_d     = '0;
               e_d     = '0;
               if (mod < W'(2)) begin
                  err_d   = 1'b1;
                  res_d   = '0;
                  state_d = DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = POW;
               end
            end
         end
         POW: begin
            mul_a = pow_q[k_prev];
            mul_b = omega_q;
            pow_d[k_q] = (k_q == '0) ? W'(1) : mul_red;
            k_d = k_q + LG'(1);
            if (k_q == LAST) state_d = MAC;
         end
         MAC: begin
            mul_a = x_q[j_q*W +: W];
            mul_b = pow_q[e_q];
            acc_d = acc_next;
            e_d   = e_q + i_q;
            j_d   = j_q + LG'(1);
            if (j_q == LAST) begin
               e_d = '0;
               if (fwd_q) begin
                  // Forward mode stores the raw sum and skips the n_inv scaling.
                  res_d[i_q*W +: W] = acc_next;
                  acc_d = '0;
                  if (i_q == LAST) state_d = DONE;
                  else             i_d = i_q + LG'(1);
               end else begin
                  state_d = SCALE;
               end
            end
         end
         SCALE: begin
            mul_a = acc_q;
            mul_b = ninv_q;
            res_d[i_q*W +: W] = mul_red;
            acc_d = '0;
            if (i_q == LAST) begin
               state_d = DONE;
            end else begin
               i_d     = i_q + LG'(1);
               state_d = MAC;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         res_q   <= '0;
         omega_q <= '0;
         ninv_q  <= '0;
         mod_q   <= '0;
         acc_q   <= '0;
         k_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         e_q     <= '0;
         err_q   <= 1'b0;
         fwd_q   <= 1'b0;
         for (int n = 0; n < N; n++) pow_q[n] <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         res_q   <= res_d;
         omega_q <= omega_d;
         ninv_q  <= ninv_d;
         mod_q   <= mod_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
         i_q     <= i_d;
         j_q     <= j_d;
         e_q     <= e_d;
         err_q   <= err_d;
         fwd_q   <= fwd_d;
         for (int n = 0; n < N; n++) pow_q[n] <= pow_d[n];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_naive_intt_seq.sv
// Directed testbench for naive_intt_seq (N=8, W=8, q=17).
`default_nettype none

module tb_naive_intt_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        fwd;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] data_in;
   logic [7:0]  omega_inv;
   logic [7:0]  n_inv;
   logic [7:0]  mod;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] data_out;
   logic        err;

   int total = 0;
   int bad   = 0;

   localparam logic [63:0] X_ONES  = 64'h0101_0101_0101_0101;
   localparam logic [63:0] X_POW15 = 64'h080D_0210_0904_0F01;
   localparam logic [63:0] X_DELTA = 64'h0000_0000_0000_0001;
   localparam logic [63:0] A_CASE1 = 64'h0000_0000_0000_0001;
   localparam logic [63:0] A_CASE2 = 64'h0000_0000_0000_0100;
   localparam logic [63:0] A_CASE3 = 64'h0F0F_0F0F_0F0F_0F0F;

   always #5 clk = ~clk;

   naive_intt_seq #(.N(8), .W(8)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef NTT_FWD_MODE_EN
      .fwd       (fwd),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .omega_inv (omega_inv),
      .n_inv     (n_inv),
      .mod       (mod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .err       (err)
   );

   // Presents one operand set for a single edge; returns #1 after that edge.
   task automatic do_accept(input logic [63:0] x, input logic [7:0] om,
                            input logic [7:0] ni, input logic [7:0] md);
      data_in   = x;
      omega_inv = om;
      n_inv     = ni;
      mod       = md;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      data_in   = 64'hDEAD_BEEF_CAFE_F00D;
      omega_inv = 8'h3;
      n_inv     = 8'h5;
      mod       = 8'h7;
   endtask

   // Cycles from the accept edge until out_valid is seen; -1 on timeout.
   task automatic wait_valid(output int lat);
      int cnt = 1;
      while (!out_valid && cnt < 300) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      lat = out_valid ? cnt : -1;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
      total++; if (data_out !== 64'h0) begin bad++; $display("FAIL reset_data got=%h want=0", data_out); end
   endtask

   task automatic test_all_ones();
      int lat;
      do_accept(X_ONES, 8'd8, 8'd15, 8'd17);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ones_in_ready_drop got=%b want=0", in_ready); end
      wait_valid(lat);
      total++; if (lat !== 81) begin bad++; $display("FAIL ones_latency got=%0d want=81", lat); end
      total++; if (data_out !== A_CASE1) begin bad++; $display("FAIL ones_data got=%h want=%h", data_out, A_CASE1); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL ones_err got=%b want=0", err); end
      release_out();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL ones_release got=%b%b want=01", out_valid, in_ready); end
   endtask

   task automatic test_shifted_delta();
      int lat;
      do_accept(X_POW15, 8'd8, 8'd15, 8'd17);
      wait_valid(lat);
      total++; if (lat !== 81) begin bad++; $display("FAIL delta_latency got=%0d want=81", lat); end
      total++; if (data_out !== A_CASE2) begin bad++; $display("FAIL delta_data got=%h want=%h", data_out, A_CASE2); end
      release_out();
   endtask

   task automatic test_backpressure();
      int lat;
      int stable_bad = 0;
      do_accept(X_DELTA, 8'd8, 8'd15, 8'd17);
      wait_valid(lat);
      total++; if (data_out !== A_CASE3) begin bad++; $display("FAIL hold_data got=%h want=%h", data_out, A_CASE3); end
      data_in   = X_ONES;
      omega_inv = 8'd8;
      n_inv     = 8'd15;
      mod       = 8'd1;
      in_valid  = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== A_CASE3) stable_bad++;
      end
      in_valid = 1'b0;
      total++; if (stable_bad !== 0) begin bad++; $display("FAIL hold_stable got=%0d want=0 bad cycles", stable_bad); end
      release_out();
      repeat (3) @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold_no_accept got=%b%b want=01", out_valid, in_ready); end
      total++; if (data_out !== A_CASE3) begin bad++; $display("FAIL hold_data_kept got=%h want=%h", data_out, A_CASE3); end
   endtask

   task automatic test_bad_modulus();
      int lat;
      do_accept(X_ONES, 8'd8, 8'd15, 8'd1);
      wait_valid(lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL err_latency got=%0d want=1", lat); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_flag got=%b want=1", err); end
      total++; if (data_out !== 64'h0) begin bad++; $display("FAIL err_data got=%h want=0", data_out); end
      release_out();
   endtask

   task automatic test_abort();
      int lat;
      do_accept(X_ONES, 8'd8, 8'd15, 8'd17);
      repeat (30) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL abort_hs got=%b%b want=10", in_ready, out_valid); end
      total++; if (data_out !== 64'h0 || err !== 1'b0) begin bad++; $display("FAIL abort_out got=%h/%b want=0/0", data_out, err); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      do_accept(X_POW15, 8'd8, 8'd15, 8'd17);
      wait_valid(lat);
      total++; if (lat !== 81) begin bad++; $display("FAIL abort_latency got=%0d want=81", lat); end
      total++; if (data_out !== A_CASE2) begin bad++; $display("FAIL abort_data got=%h want=%h", data_out, A_CASE2); end
      release_out();
   endtask

`ifdef NTT_FWD_MODE_EN
   task automatic test_forward();
      int lat;
      fwd = 1'b1;
      do_accept(64'h0000_0000_0000_0100, 8'd15, 8'd15, 8'd17);
      fwd = 1'b0;
      wait_valid(lat);
      total++; if (lat !== 73) begin bad++; $display("FAIL fwd_latency got=%0d want=73", lat); end
      total++; if (data_out !== X_POW15) begin bad++; $display("FAIL fwd_data got=%h want=%h", data_out, X_POW15); end
      release_out();
   endtask
`endif

   initial begin
      rst       = 1'b1;
      fwd       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      omega_inv = '0;
      n_inv     = '0;
      mod       = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      test_all_ones();
      test_shifted_delta();
      test_backpressure();
      test_bad_modulus();
      test_abort();
`ifdef NTT_FWD_MODE_EN
      test_forward();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
